// File: rtl/fptd_iter_controller_if.sv
// Host/decoder-side bundle for the FPTD iteration controller.
// master drives the frame request and decoder feedback; slave is the controller.
interface fptd_iter_controller_if #(
   parameter int FL     = 40,
   parameter int M      = 6,
   parameter int ITER_W = 6
);
   logic              start;
   logic [ITER_W-1:0] iter_limit;
   logic [FL*M-1:0]   be1;
   logic [FL-1:0]     razor_err;
   logic              dec_nClear;
   logic              Enable_Odd;
   logic              Enable_Even;
   logic              Enable_Term;
   logic              busy;
   logic              done;
   logic [FL-1:0]     hard_bits;
   logic [ITER_W-1:0] iter_count;
   logic [7:0]        replay_count;
   logic              replay_fail;
   logic              early_stop;

   modport master (
      output start, iter_limit, be1, razor_err,
      input  dec_nClear, Enable_Odd, Enable_Even, Enable_Term,
      input  busy, done, hard_bits, iter_count,
      input  replay_count, replay_fail, early_stop
   );

   modport slave (
      input  start, iter_limit, be1, razor_err,
      output dec_nClear, Enable_Odd, Enable_Even, Enable_Term,
      output busy, done, hard_bits, iter_count,
      output replay_count, replay_fail, early_stop
   );
endinterface

// File: rtl/fptd_iter_controller.sv
// Iteration sequencer for the razor-protected FPTD lower decoder array.
// Define FPTD_EARLY_STOP_EN to build the decision-stability early stop.
module fptd_iter_controller #(
   parameter int FL         = 40,
   parameter int M          = 6,
   parameter int MAX_ITER   = 32,
   parameter int ITER_W     = $clog2(MAX_ITER+1),
   parameter int STABLE_K   = 2,
   parameter int MAX_REPLAY = 3
) (
   input logic Clock,
   input logic nReset,
   input logic nClear,
   fptd_iter_controller_if.slave bus
);

   typedef enum logic [3:0] {
      IDLE, CLEAR, TERM, ODD, ODD_CHK,
      EVEN, EVEN_CHK, CHECK, DONE
   } state_t;

   state_t            state, nxt;
   logic              rst;
   logic              err;
   logic              replay_ok;
   logic              stop_stable;
   logic [ITER_W-1:0] limit, lim_clamp, iter_cnt, iter_inc;
   logic [7:0]        half_replay, replay_cnt;
   logic              fail_r, early_r;
   logic [FL-1:0]     hb, hard_r;
   logic              be1_unused;

   assign rst       = !nReset || !nClear;
   assign err       = |bus.razor_err;
   assign replay_ok = half_replay < 8'(MAX_REPLAY);
   assign iter_inc  = iter_cnt + 1'b1;
   // Only the sign bit of each extrinsic word matters here
   assign be1_unused = ^bus.be1;

   always_comb begin
      hb = '0;
      for (int i = 0; i < FL; i++)
         hb[i] = bus.be1[i*M + M-1];
   end

   always_comb begin
      lim_clamp = bus.iter_limit;
      if (bus.iter_limit == '0)
         lim_clamp = ITER_W'(1);
      else if (bus.iter_limit > ITER_W'(MAX_ITER))
         lim_clamp = ITER_W'(MAX_ITER);
   end

`ifdef FPTD_EARLY_STOP_EN
   localparam int SW = $clog2(STABLE_K+1);
   logic [FL-1:0] prev;
   logic          prev_vld;
   logic [SW-1:0] stable, stable_nxt;

   always_comb begin
      stable_nxt = '0;
      if (prev_vld && hb == prev)
         stable_nxt = (stable == SW'(STABLE_K)) ?
                      stable : stable + 1'b1;
   end

   assign stop_stable = stable_nxt == SW'(STABLE_K);

   always_ff @(posedge Clock) begin
      if (rst) begin
         prev     <= '0;
         prev_vld <= 1'b0;
         stable   <= '0;
      end else if (state == IDLE && bus.start) begin
         prev_vld <= 1'b0;
         stable   <= '0;
      end else if (state == CHECK) begin
         prev     <= hb;
         prev_vld <= 1'b1;
         stable   <= stable_nxt;
      end
   end
`else
   localparam int STABLE_K_UNUSED = STABLE_K;
   assign stop_stable = 1'b0;
`endif

   always_ff @(posedge Clock) begin
      if (rst) state <= IDLE;
      else     state <= nxt;
   end

   always_comb begin
      nxt = state;
      unique case (state)
         IDLE:     if (bus.start) nxt = CLEAR;
         CLEAR:    nxt = TERM;
         TERM:     nxt = ODD;
         ODD:      nxt = ODD_CHK;
         ODD_CHK:  nxt = (err && replay_ok) ? ODD : EVEN;
         EVEN:     nxt = EVEN_CHK;
         EVEN_CHK: nxt = (err && replay_ok) ? EVEN : CHECK;
         CHECK:    nxt = (stop_stable || iter_inc == limit) ?
                         DONE : ODD;
         DONE:     nxt = IDLE;
         default:  nxt = IDLE;
      endcase
   end

   always_ff @(posedge Clock) begin
      if (rst) begin
         limit       <= '0;
         half_replay <= '0;
         iter_cnt    <= '0;
         replay_cnt  <= '0;
         fail_r      <= 1'b0;
         early_r     <= 1'b0;
         hard_r      <= '0;
      end else begin
         unique case (state)
            IDLE: if (bus.start) begin
               limit       <= lim_clamp;
               half_replay <= '0;
               iter_cnt    <= '0;
               replay_cnt  <= '0;
               fail_r      <= 1'b0;
               early_r     <= 1'b0;
            end
            ODD_CHK, EVEN_CHK: begin
               if (err && replay_ok) begin
                  half_replay <= half_replay + 1'b1;
                  if (replay_cnt != 8'hFF)
                     replay_cnt <= replay_cnt + 1'b1;
               end else begin
                  half_replay <= '0;
                  if (err) fail_r <= 1'b1;
               end
            end
            CHECK: begin
               iter_cnt <= iter_inc;
               hard_r   <= hb;
               if (stop_stable) early_r <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign bus.dec_nClear   = state != CLEAR;
   assign bus.Enable_Term  = state == TERM;
   assign bus.Enable_Odd   = state == ODD;
   assign bus.Enable_Even  = state == EVEN;
   assign bus.busy         = state != IDLE;
   assign bus.done         = state == DONE;
   assign bus.hard_bits    = hard_r;
   assign bus.iter_count   = iter_cnt;
   assign bus.replay_count = replay_cnt;
   assign bus.replay_fail  = fail_r;
   assign bus.early_stop   = early_r;

endmodule

// File: tb/tb_fptd_iter_controller.sv
// Bench for fptd_iter_controller: directed and random frames
// checked against a frame-level timing/result model.
module tb_fptd_iter_controller;
   localparam int FL         = 40;
   localparam int M          = 6;
   localparam int MAX_ITER   = 32;
   localparam int ITER_W     = $clog2(MAX_ITER+1);
   localparam int STABLE_K   = 2;
   localparam int MAX_REPLAY = 3;

   logic clk = 1'b0;
   logic nReset = 1'b0;
   logic nClear = 1'b1;
   int   tests = 0;
   int   fails = 0;
   int   errs[$];

   fptd_iter_controller_if #(.FL(FL), .M(M), .ITER_W(ITER_W)) bus();

   fptd_iter_controller #(
      .FL(FL), .M(M), .MAX_ITER(MAX_ITER), .ITER_W(ITER_W),
      .STABLE_K(STABLE_K), .MAX_REPLAY(MAX_REPLAY)
   ) dut (
      .Clock(clk), .nReset(nReset), .nClear(nClear), .bus(bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs,
                        input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_idle(input string tag);
      check({tag, "_enables"},
            {61'd0, bus.Enable_Term, bus.Enable_Odd, bus.Enable_Even}, 0);
      check({tag, "_busy"}, {63'd0, bus.busy}, 0);
      check({tag, "_done"}, {63'd0, bus.done}, 0);
      check({tag, "_nclr"}, {63'd0, bus.dec_nClear}, 1);
   endtask

   // Starts a frame, plays razor responses from errs[] (fire count per
   // half-iteration) and compares against the frame-level model.
   task automatic run_frame(input string tag, input int lim,
                            input logic [FL*M-1:0] b, input bit poke);
      int L, n, early, rep, fail, dc, e, r;
      int cyc, done_cyc, clr_cyc, term_cyc, h, a, last;
      bit hold, excl_bad, busy_bad;
      logic [FL-1:0] hb_exp;
      L = (lim == 0) ? 1 : (lim > MAX_ITER ? MAX_ITER : lim);
      n = L;
      early = 0;
`ifdef FPTD_EARLY_STOP_EN
      if (L >= STABLE_K + 1) begin
         n = STABLE_K + 1;
         early = 1;
      end
`endif
      rep = 0; fail = 0; dc = 3 + n;
      for (int k = 0; k < 2*n; k++) begin
         e = (k < errs.size()) ? errs[k] : 0;
         r = (e < MAX_REPLAY) ? e : MAX_REPLAY;
         rep += r;
         if (e > MAX_REPLAY) fail = 1;
         dc += 2 + 2*r;
      end
      if (rep > 255) rep = 255;
      for (int i = 0; i < FL; i++) hb_exp[i] = b[i*M + M-1];

      @(negedge clk);
      bus.iter_limit = ITER_W'(lim);
      bus.be1 = b;
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      bus.iter_limit = ITER_W'($urandom);
      cyc = 1; done_cyc = -1; clr_cyc = -1; term_cyc = -1;
      h = -1; a = 0; last = 0; hold = 0;
      excl_bad = 0; busy_bad = 0;
      while (done_cyc < 0 && cyc < 2000) begin
         if (int'(bus.Enable_Term) + int'(bus.Enable_Odd) +
             int'(bus.Enable_Even) > 1) excl_bad = 1;
         if (bus.busy !== 1'b1) busy_bad = 1;
         if (bus.dec_nClear === 1'b0 && clr_cyc < 0) clr_cyc = cyc;
         if (bus.Enable_Term === 1'b1 && term_cyc < 0) term_cyc = cyc;
         if (bus.Enable_Odd === 1'b1 || bus.Enable_Even === 1'b1) begin
            if ((bus.Enable_Odd ? 1 : 2) != last) begin
               h++;
               a = 0;
               last = bus.Enable_Odd ? 1 : 2;
            end
            e = (h < errs.size()) ? errs[h] : 0;
            bus.razor_err = (a < e) ?
               (FL'($urandom) | FL'(1) << $urandom_range(0, FL-1)) : '0;
            a++;
            hold = 1;
         end else if (hold) begin
            hold = 0;
         end else begin
            bus.razor_err = FL'({$urandom, $urandom});
         end
         if (poke && cyc == 5) begin
            bus.start = 1'b1;
            bus.iter_limit = ITER_W'($urandom);
         end else begin
            bus.start = 1'b0;
         end
         if (bus.done === 1'b1) done_cyc = cyc;
         else begin
            @(negedge clk);
            cyc++;
         end
      end
      bus.razor_err = '0;
      bus.start = 1'b0;
      check({tag, "_done_cyc"}, 64'(done_cyc), 64'(dc));
      check({tag, "_clr_cyc"}, 64'(clr_cyc), 1);
      check({tag, "_term_cyc"}, 64'(term_cyc), 2);
      check({tag, "_excl"}, {63'd0, excl_bad}, 0);
      check({tag, "_busy"}, {63'd0, busy_bad}, 0);
      check({tag, "_iter"}, 64'(bus.iter_count), 64'(n));
      check({tag, "_replays"}, 64'(bus.replay_count), 64'(rep));
      check({tag, "_rfail"}, 64'(bus.replay_fail), 64'(fail));
      check({tag, "_early"}, 64'(bus.early_stop), 64'(early));
      check({tag, "_hard"}, 64'(bus.hard_bits), 64'(hb_exp));
      @(negedge clk);
      check_idle({tag, "_after"});
      check({tag, "_hold_iter"}, 64'(bus.iter_count), 64'(n));
      check({tag, "_hold_hard"}, 64'(bus.hard_bits), 64'(hb_exp));
   endtask

   task automatic rand_be1(output logic [FL*M-1:0] b);
      for (int i = 0; i < FL*M; i++) b[i] = 1'($urandom_range(0, 1));
   endtask

   initial begin
      logic [FL*M-1:0] b;
      int lim, w;
      bus.start = 1'b0;
      bus.iter_limit = '0;
      bus.be1 = '0;
      bus.razor_err = '0;
      repeat (3) @(negedge clk);
      check_idle("reset");
      check("reset_iter", 64'(bus.iter_count), 0);
      check("reset_hard", 64'(bus.hard_bits), 0);
      check("reset_rep", 64'(bus.replay_count), 0);
      check("reset_flags", {62'd0, bus.replay_fail, bus.early_stop}, 0);
      nReset = 1'b1;

      errs.delete();
      rand_be1(b);
      run_frame("lim4", 4, b, 0);

      b = '0;
      for (int i = 0; i < FL; i += 2) b[i*M + M-1] = 1'b1;
      run_frame("alt10", 10, b, 0);
      check("alt10_hex", 64'(bus.hard_bits), 64'h55_5555_5555);

      errs.delete();
      errs.push_back(1);
      rand_be1(b);
      run_frame("replay1", 2, b, 0);

      errs.delete();
      errs.push_back(9);
      errs.push_back(9);
      run_frame("replay_held", 1, b, 0);

      errs.delete();
      run_frame("lim0", 0, b, 0);
      run_frame("lim63", 63, b, 1);

      // Reset in the middle of a frame
      @(negedge clk);
      bus.iter_limit = ITER_W'(10);
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      w = 0;
      while (bus.Enable_Even !== 1'b1 && w < 50) begin
         @(negedge clk);
         w++;
      end
      check("rst_mid_seen_even", {63'd0, bus.Enable_Even}, 1);
      nReset = 1'b0;
      @(negedge clk);
      check_idle("rst_mid");
      check("rst_mid_iter", 64'(bus.iter_count), 0);
      nReset = 1'b1;
      w = 0;
      repeat (20) begin
         @(negedge clk);
         if (bus.done !== 1'b0 || bus.busy !== 1'b0) w++;
      end
      check("rst_mid_quiet", 64'(w), 0);
      errs.delete();
      rand_be1(b);
      run_frame("post_rst", 3, b, 0);

      // Soft clear behaves like reset
      @(negedge clk);
      bus.iter_limit = ITER_W'(5);
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (6) @(negedge clk);
      nClear = 1'b0;
      @(negedge clk);
      check_idle("nclear");
      nClear = 1'b1;

      for (int t = 0; t < 25; t++) begin
         errs.delete();
         for (int k = 0; k < 2*MAX_ITER; k++)
            errs.push_back(($urandom_range(0, 9) < 7) ?
                           0 : int'($urandom_range(1, 5)));
         lim = int'($urandom_range(0, 40));
         rand_be1(b);
         run_frame($sformatf("rnd%0d", t), lim, b,
                   1'($urandom_range(0, 1)));
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/fptd_iter_controller.md
Name: fptd_iter_controller

Overview:
- Iteration sequencer for the razor-protected FPTD lower decoder array.
- Generates the Term/Odd/Even section enables and the decoder clear for a runtime-selectable number of iterations.
- Replays a half-iteration when razor flags fire, with a bounded retry count.
- Extracts hard decisions from be1 and stops early once decisions are stable, returning frame status to the host sequencer.

Parameters:
FL, 40, frame length (section count excluding termination).
M, 6, be1 word width (signed).
MAX_ITER, 32, hard maximum iterations.
ITER_W, $clog2(MAX_ITER+1), iteration counter width.
STABLE_K, 2, consecutive unchanged-decision iterations required for early stop (>=1).
MAX_REPLAY, 3, replays allowed per half-iteration.

Ports:
Clock  in  1  system clock.
nReset  in  1  synchronous, active-low reset.
nClear  in  1  synchronous active-low soft clear; same effect as nReset.
start  in  1  one-cycle request to decode a frame.
iter_limit  in  ITER_W  iterations for this frame; sampled on accepted start.
be1  in  FL*M  signed extrinsic words from decoder; bit M-1 of each word is its sign.
razor_err  in  FL  OR of all per-section razor flags; valid the cycle after an enable pulse.
dec_nClear  out  1  active-low clear to decoder array.
Enable_Odd  out  1  odd-section enable.
Enable_Even  out  1  even-section enable.
Enable_Term  out  1  termination-section enable.
busy  out  1  frame in progress.
done  out  1  one-cycle frame-complete pulse.
hard_bits  out  FL  hard decisions (1 = sign bit set).
iter_count  out  ITER_W  iterations completed.
replay_count  out  8  replays this frame, saturating at 255.
replay_fail  out  1  sticky per frame; a half exhausted MAX_REPLAY.
early_stop  out  1  frame ended by stability, not by limit.

Behaviour:
- Reset (nReset or nClear low at edge): state IDLE. All outputs 0 except dec_nClear=1. Counters and previous-decision register cleared. Reset takes priority mid-frame; the frame is abandoned with no done pulse.
- States: IDLE, CLEAR, TERM, ODD, ODD_CHK, EVEN, EVEN_CHK, CHECK, DONE. One cycle each.
- IDLE:
  - start=1 -> CLEAR. Latch iter_limit: 0 clamps to 1, >MAX_ITER clamps to MAX_ITER.
  - Clear iter_count, replay_count, replay_fail, early_stop, stable counter and prev-valid flag.
  - start while busy is ignored.
- CLEAR: dec_nClear=0 -> TERM.
- TERM: Enable_Term=1 -> ODD.
- ODD: Enable_Odd=1 -> ODD_CHK.
- ODD_CHK:
  - If |razor_err and half_replay<MAX_REPLAY -> ODD; half_replay++, replay_count++ (saturating).
  - Else if |razor_err -> replay_fail=1, then EVEN.
  - Else -> EVEN.
  - half_replay clears on leaving to EVEN.
- EVEN / EVEN_CHK: identical to ODD / ODD_CHK with Enable_Even; exit goes to CHECK.
- CHECK:
  - iter_count++. Form hb = sign bits of be1.
  - If prev-valid and hb==prev: stable++ (saturate at STABLE_K). Else stable=0.
  - prev=hb, prev-valid=1, hard_bits<=hb.
  - If stable==STABLE_K: early_stop=1, -> DONE.
  - Else if iter_count==limit -> DONE.
  - Else -> ODD.
- DONE: done=1 for one cycle -> IDLE.
  - hard_bits, iter_count, replay_count, replay_fail and early_stop hold until the next accepted start.
- busy=1 in every state except IDLE.
- Enables are mutually exclusive; at most one is high per cycle.
- Fault-free latency: done asserts 3+5*iters cycles after the edge sampling start. Each replay adds 2 cycles.

Optional Feature:
- Macro FPTD_EARLY_STOP_EN.
- Defined: stability check and early_stop as above.
- Undefined: the stable counter and prev register are not built; every frame runs exactly the clamped limit; early_stop tied 0; hard_bits still updated each CHECK.

Test Plan:
- No macro, iter_limit=4, razor_err=0, be1 constant -> Enable_Term high cycle 2, Enable_Odd cycles 3,8,13,18; done at cycle 23; iter_count=4; replay_count=0.
- FPTD_EARLY_STOP_EN, STABLE_K=2, iter_limit=10, be1 constant with alternating signs -> early_stop=1; iter_count=3; done at cycle 18; hard_bits=0x5555555555 for FL=40, alternating bits starting with bit0=1.
- iter_limit=2, razor_err=0x1 during the first ODD_CHK only -> Enable_Odd pulses twice in iteration 1; replay_count=1; replay_fail=0; done at cycle 15.
- razor_err held at 0x1 throughout, iter_limit=1 -> 3 replays per half; replay_count=6; replay_fail=1; done at cycle 20.
- iter_limit=0 -> treated as 1; done at cycle 8. iter_limit=63 -> runs 32 iterations.
- nReset low while in EVEN -> next cycle all enables 0, busy=0, dec_nClear=1, no done pulse; a new start is accepted normally.
